hex_sum_bcd_converter: RTL
==========================

HEX_SUM_BCD_CONVERTER -- requirements
Module: hex_sum_bcd_converter

Interface
REQ-001 Parameter IN_W, default 7, SHALL set the binary input width; 7 covers the full hex-digit-sum range 0..120.
REQ-002 Parameter NUM_DIGITS, default 3, SHALL set the BCD output digit count; NUM_DIGITS SHALL satisfy 10^NUM_DIGITS > 2^IN_W.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  SHALL request a conversion of bin_in.
REQ-006 bin_in  input  IN_W  SHALL be the binary value to convert, driven by the upstream hex-digit-sum stage.
REQ-007 busy  output  1  SHALL be high while a conversion is in progress.
REQ-008 done  output  1  SHALL be a single-cycle pulse marking a new result.
REQ-009 bcd_out  output  4*NUM_DIGITS  SHALL hold the last result, ones digit in [3:0], tens in [7:4], hundreds in [11:8].

Function
REQ-010 The block SHALL use a three-state FSM: IDLE, CONVERT, DONE.
REQ-011 In IDLE with start=1, the block SHALL capture bin_in into a shift register, clear the BCD scratch register, load the iteration counter with IN_W, and enter CONVERT.
REQ-012 Each CONVERT cycle SHALL first add 3 to every scratch digit >= 5, then shift the {scratch, binary} register left by one bit, then decrement the counter.
REQ-013 CONVERT SHALL last exactly IN_W cycles, then transition to DONE.
REQ-014 DONE SHALL last one cycle, copy scratch to bcd_out, drive done=1, and return to IDLE.
REQ-015 Latency: done SHALL go high IN_W+1 rising edges after the edge that samples start, which is 8 edges at default.
REQ-016 busy SHALL be 1 in CONVERT and 0 in IDLE and DONE; busy and done SHALL never be high together.
REQ-017 start SHALL be ignored in CONVERT and DONE, with no queuing; bin_in SHALL be sampled only on the accepting edge.
REQ-018 Back-to-back: start held high SHALL begin a new conversion on the first IDLE cycle after DONE, giving a throughput of one result per IN_W+2 cycles.
REQ-019 bcd_out SHALL hold its value between completions and change only in DONE.
REQ-020 Each digit SHALL be 0..9 for every input 0..2^IN_W-1.

Reset
REQ-021 rst=1 SHALL force state IDLE, busy=0, done=0, bcd_out=0, and clear the counter and scratch registers on the next rising edge.
REQ-022 rst SHALL take priority over start; reset during CONVERT or DONE SHALL abort without updating bcd_out or pulsing done.
REQ-023 After rst deasserts, the first start SHALL be accepted on the first edge with rst=0.

Structure
REQ-024 Shared package hex_sum_pkg SHALL hold IN_W and NUM_DIGITS defaults, the FSM state encodings (IDLE=2'd0, CONVERT=2'd1, DONE=2'd2), and the counter width constant.
REQ-025 One combinational sub-module, bcd_add3 (4-bit in, 4-bit out, adds 3 when the input is >= 5), SHALL be instantiated NUM_DIGITS times.
REQ-026 The counter SHALL be clog2(IN_W+1) bits wide; all outputs SHALL be registered.

Verification
REQ-027 Reset then start with bin_in=0 -> done after 8 edges, bcd_out=12'h000.
REQ-028 bin_in=120 (max hex sum, digits all F) -> bcd_out=12'h120; bin_in=127 -> 12'h127; bin_in=99 -> 12'h099.
REQ-029 Start with bin_in=45, then start again with bin_in=7 on cycle 3 of CONVERT -> second start ignored, bcd_out=12'h045, one done pulse only.
REQ-030 Start with bin_in=88, rst=1 on cycle 4 of CONVERT -> busy=0, done never pulses, bcd_out=12'h000; a following start with bin_in=5 -> 12'h005.
REQ-031 start held high, bin_in stepping 0..127 -> one done every 9 cycles, each bcd_out matching a decimal reference model.
REQ-032 Exhaustive sweep of 0..127 -> every digit <= 9 and busy/done mutually exclusive on every cycle.

Source files
------------

// File: rtl/hex_sum_pkg.sv
// -----------------------------------------------------------------------------
// hex_sum_pkg
// Shared definitions for the hex-digit-sum to BCD converter:
//   - default binary input width and BCD digit count
//   - FSM state encoding
//   - counter width constant and a helper that sizes the iteration counter
// -----------------------------------------------------------------------------
package hex_sum_pkg;

  localparam int IN_W_DEF       = 7;  // 0..120 digit sums fit in 7 bits
  localparam int NUM_DIGITS_DEF = 3;  // 10^3 > 2^7

  // The iteration counter must hold the value IN_W itself.
  function automatic int cnt_width(input int in_w);
    return $clog2(in_w + 1);
  endfunction

  localparam int CNT_W = cnt_width(IN_W_DEF);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more so
// that the following left shift carries correctly into the next digit.
// Ports:
//   digit_i  4-bit BCD digit before correction
//   digit_o  4-bit corrected digit
// -----------------------------------------------------------------------------
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/hex_sum_bcd_converter.sv
// -----------------------------------------------------------------------------
// hex_sum_bcd_converter
// Sequential binary-to-BCD converter (shift-and-add-3) for the output of the
// hex-digit-sum stage. One bit is processed per CONVERT cycle.
// Ports:
//   clk      clock, all state on rising edge
//   rst      synchronous active-high reset
//   start    request conversion of bin_in (honoured only in IDLE)
//   bin_in   binary value, sampled only on the accepting edge
//   busy     high while converting (registered)
//   done     one-cycle pulse marking a new bcd_out value (registered)
//   bcd_out  last result, ones digit in [3:0], tens in [7:4], ...
// -----------------------------------------------------------------------------
module hex_sum_bcd_converter
  import hex_sum_pkg::*;
#(
  parameter int IN_W       = IN_W_DEF,
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [IN_W-1:0]         bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd_out
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = cnt_width(IN_W);
  localparam logic [CW-1:0] CNT_LOAD = CW'(IN_W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e          state_q, state_d;
  logic [IN_W-1:0] bin_q, bin_d;
  logic [BW-1:0]   scratch_q, scratch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Correct every digit before the shift.
  logic [BW-1:0] adj;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .digit_i (scratch_q[4*gi +: 4]),
        .digit_o (adj[4*gi +: 4])
      );
    end
  endgenerate

  // The top bit of the corrected scratch is always shifted out; it can never
  // be set because 10^NUM_DIGITS exceeds the input range.
  logic [BW+IN_W-1:0] shifted;
  logic               unused_adj_msb;

  assign shifted        = {adj[BW-2:0], bin_q, 1'b0};
  assign unused_adj_msb = adj[BW-1];

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_d     = bin_in;
          scratch_d = '0;
          cnt_d     = CNT_LOAD;
          state_d   = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        {scratch_d, bin_d} = shifted;
        cnt_d              = cnt_q - CNT_ONE;
        // The cycle that consumes the last bit leaves for DONE.
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_CONVERT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule
